// File: rtl/prog_counter.sv
// prog_counter: prescaled up/down counter with modulo, wrap/saturate and tc.
// Optional capture port set under `PCNT_CAPTURE_EN`.
//
// Ports:
//   clk, rstn_n       clock, async active-low reset
//   en                enables prescaler and counter
//   dir               1 = up, 0 = down
//   mode_sat          0 = wrap, 1 = saturate at boundary
//   clr, load         sync clear / sync load of load_val (clr wins)
//   load_val, modulo  load value, upper bound of range 0..modulo
//   presc             prescale divisor minus 1
//   out_en            output-enable request
//   count, tc         registered count, registered terminal-count pulse
//   oe                {WIDTH{out_en}}, combinational
//   cap/cap_val/cap_vld  capture strobe and result (PCNT_CAPTURE_EN only)
module prog_counter #(
    parameter int WIDTH = 8,
    parameter int PW    = 4
) (
    input  logic             clk,
    input  logic             rstn_n,
    input  logic             en,
    input  logic             dir,
    input  logic             mode_sat,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic [WIDTH-1:0] modulo,
    input  logic [PW-1:0]    presc,
    input  logic             out_en,
`ifdef PCNT_CAPTURE_EN
    input  logic             cap,
    output logic [WIDTH-1:0] cap_val,
    output logic             cap_vld,
`endif
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic [WIDTH-1:0] oe
);

    logic [WIDTH-1:0] count_q, count_d;
    logic [PW-1:0]    pc_q, pc_d;
    logic             tc_q, tc_d;
    logic             tick;
    logic             at_bnd;

    // pc compares for equality only, so lowering presc below pc makes
    // pc run on and wrap mod 2^PW before the next tick.
    assign tick = en && (pc_q == presc);

    assign at_bnd = dir ? (count_q >= modulo) : (count_q == '0);

    always_comb begin
        pc_d = pc_q;
        if (clr || load)
            pc_d = '0;
        else if (en)
            pc_d = tick ? '0 : pc_q + PW'(1);
    end

    always_comb begin
        count_d = count_q;
        tc_d    = 1'b0;
        if (clr) begin
            count_d = '0;
        end else if (load) begin
            count_d = load_val;
        end else if (tick) begin
            // Saturate holds still pulse tc on every boundary tick.
            tc_d = at_bnd;
            if (dir) begin
                if (!at_bnd)
                    count_d = count_q + WIDTH'(1);
                else if (!mode_sat)
                    count_d = '0;
            end else begin
                if (!at_bnd)
                    count_d = count_q - WIDTH'(1);
                else if (!mode_sat)
                    count_d = modulo;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn_n) begin
        if (!rstn_n) begin
            count_q <= '0;
            pc_q    <= '0;
            tc_q    <= 1'b0;
        end else begin
            count_q <= count_d;
            pc_q    <= pc_d;
            tc_q    <= tc_d;
        end
    end

    assign count = count_q;
    assign tc    = tc_q;
    assign oe    = {WIDTH{out_en}};

`ifdef PCNT_CAPTURE_EN
    logic [WIDTH-1:0] cap_val_q;
    logic             cap_vld_q;

    // Snapshot is the pre-update count, independent of en/clr/load.
    always_ff @(posedge clk or negedge rstn_n) begin
        if (!rstn_n) begin
            cap_val_q <= '0;
            cap_vld_q <= 1'b0;
        end else begin
            cap_vld_q <= cap;
            if (cap)
                cap_val_q <= count_q;
        end
    end

    assign cap_val = cap_val_q;
    assign cap_vld = cap_vld_q;
`endif

endmodule

// File: tb/tb_prog_counter.sv
// Testbench for prog_counter (WIDTH=8, PW=4): directed steps with a
// scoreboard queue of expected count/tc fed from a behavioural model.
module tb_prog_counter;

    logic       clk = 1'b0;
    logic       rstn_n = 1'b0;
    logic       en = 1'b0, dir = 1'b1, mode_sat = 1'b0;
    logic       clr = 1'b0, load = 1'b0, out_en = 1'b0;
    logic [7:0] load_val = '0, modulo = 8'd255;
    logic [3:0] presc = '0;
    logic [7:0] count, oe;
    logic       tc;
`ifdef PCNT_CAPTURE_EN
    logic       cap = 1'b0;
    logic [7:0] cap_val;
    logic       cap_vld;
`endif

    prog_counter #(.WIDTH(8), .PW(4)) dut (
        .clk(clk), .rstn_n(rstn_n), .en(en), .dir(dir),
        .mode_sat(mode_sat), .clr(clr), .load(load),
        .load_val(load_val), .modulo(modulo), .presc(presc),
        .out_en(out_en),
`ifdef PCNT_CAPTURE_EN
        .cap(cap), .cap_val(cap_val), .cap_vld(cap_vld),
`endif
        .count(count), .tc(tc), .oe(oe)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned c;
        bit          t;
    } exp_t;

    exp_t sbq[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   tc_seen = 0;

    // Reference state, kept as plain integers.
    int unsigned m_cnt = 0, m_pc = 0;
    bit          m_tc = 0;

    task automatic chk(input string tag, input int unsigned obs,
                       input int unsigned exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_step();
        bit tk;
        tk = 0;
        m_tc = 0;
        if (clr) begin
            m_cnt = 0; m_pc = 0;
        end else if (load) begin
            m_cnt = load_val; m_pc = 0;
        end else if (en) begin
            tk = (m_pc == presc);
            m_pc = tk ? 0 : (m_pc + 1) % 16;
        end
        if (tk && !clr && !load) begin
            if (dir) begin
                if (m_cnt < modulo) m_cnt = m_cnt + 1;
                else begin
                    m_tc = 1;
                    if (!mode_sat) m_cnt = 0;
                end
            end else begin
                if (m_cnt > 0) m_cnt = m_cnt - 1;
                else begin
                    m_tc = 1;
                    if (!mode_sat) m_cnt = modulo;
                end
            end
        end
    endtask

    // Push the expectation, let one edge pass, then pop and compare.
    task automatic step(input string tag);
        exp_t e;
        model_step();
        e.c = m_cnt;
        e.t = m_tc;
        sbq.push_back(e);
        @(posedge clk);
        #1;
        e = sbq.pop_front();
        chk({tag, ".count"}, count, e.c);
        chk({tag, ".tc"}, tc, e.t);
        if (tc) tc_seen++;
    endtask

    task automatic run(input string tag, input int n);
        for (int i = 0; i < n; i++) step(tag);
    endtask

    initial begin
        // Reset state
        #2;
        chk("rst.count", count, 0);
        chk("rst.tc", tc, 0);
        chk("rst.oe0", oe, 8'h00);
        out_en = 1'b1;
        #1;
        chk("rst.oe1", oe, 8'hff);
        @(negedge clk);
        rstn_n = 1'b1;

        // Full 8-bit up wrap, presc=0
        en = 1; dir = 1; presc = 0; modulo = 255; mode_sat = 0;
        tc_seen = 0;
        run("wrap255", 255);
        chk("wrap255.at255", count, 255);
        chk("wrap255.notc", tc_seen, 0);
        step("wrap255.edge");
        chk("wrap255.zero", count, 0);
        chk("wrap255.tc", tc, 1);
        step("wrap255.after");
        chk("wrap255.tcone", tc_seen, 1);

        // Prescaled modulo-5 run with an en gap of 7 cycles
        clr = 1; step("clr"); clr = 0;
        presc = 3; modulo = 5;
        tc_seen = 0;
        run("presc", 20);
        chk("presc.mid", count, 5);
        en = 0; run("presc.gap", 7); en = 1;
        chk("presc.hold", count, 5);
        run("presc", 28);
        chk("presc.tcs", tc_seen, 2);
        chk("presc.end", count, 0);

        // Down with saturation from 3
        presc = 0; dir = 0; mode_sat = 1;
        load_val = 8'd3; load = 1; step("dsat.load"); load = 0;
        chk("dsat.ld", count, 3);
        tc_seen = 0;
        run("dsat", 6);
        chk("dsat.cnt", count, 0);
        chk("dsat.tcs", tc_seen, 3);
        mode_sat = 0;
        step("dwrap");
        chk("dwrap.mod", count, 5);
        chk("dwrap.tc", tc, 1);

        // Load above modulo, then clr+load together
        dir = 1; modulo = 10; load_val = 8'd200;
        load = 1; step("ld200"); load = 0;
        chk("ld200.val", count, 200);
        step("ld200.tick");
        chk("ld200.wrap", count, 0);
        chk("ld200.tc", tc, 1);
        run("ld200", 3);
        clr = 1; load = 1; step("clrld"); clr = 0; load = 0;
        chk("clrld.cnt", count, 0);

        // Async reset mid-prescale at count=7, pc=2
        presc = 3; modulo = 20;
        run("pre", 30);
        chk("pre.cnt", count, 7);
        #2 rstn_n = 0;
        #1;
        chk("arst.count", count, 0);
        chk("arst.tc", tc, 0);
        out_en = 0;
        #1;
        chk("arst.oe", oe, 8'h00);
        m_cnt = 0; m_pc = 0; m_tc = 0;
        #1 rstn_n = 1;
        out_en = 1;
        run("post", 3);
        chk("post.wait", count, 0);
        step("post");
        chk("post.first", count, 1);
        chk("post.oe", oe, 8'hff);

`ifdef PCNT_CAPTURE_EN
        presc = 0; modulo = 100; load_val = 8'd42;
        load = 1; step("cap.load"); load = 0;
        cap = 1; step("cap"); cap = 0;
        chk("cap.count", count, 43);
        chk("cap.val", cap_val, 42);
        chk("cap.vld", cap_vld, 1);
        step("cap.after");
        chk("cap.vld0", cap_vld, 0);
`endif

        chk("sbq.empty", sbq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/prog_counter.md
Name: prog_counter

Overview:
- Parametrised successor to the team's free-running 8-bit counter.
- Adds configurable width, programmable modulo, up/down direction, prescaler, synchronous load/clear, wrap-or-saturate mode and a terminal-count pulse.
- Intended as the reusable timebase/event counter behind the dedicated and bidirectional IO pins of top-level project wrappers; drives a replicated output-enable bus like its predecessor.

Parameters:
- WIDTH, 8, counter, load value and modulo width in bits (≥2).
- PW, 4, prescaler width in bits (≥1).

Ports:
- clk      in   1      clock, all state on rising edge
- rstn_n   in   1      reset, asynchronous, active-low
- en       in   1      count enable; gates prescaler and counter
- dir      in   1      1 = count up, 0 = count down
- mode_sat in   1      0 = wrap at boundary, 1 = saturate at boundary
- clr      in   1      synchronous clear
- load     in   1      synchronous load of load_val
- load_val in   WIDTH  value loaded on load
- modulo   in   WIDTH  upper boundary; counter range 0..modulo
- presc    in   PW     prescale divisor minus 1
- out_en   in   1      output-enable request
- count    out  WIDTH  current count (registered)
- tc       out  1      terminal-count pulse (registered)
- oe       out  WIDTH  {WIDTH{out_en}}, combinational

Behaviour:
- Reset (rstn_n=0, async): count=0, prescaler counter pc=0, tc=0. Capture state is also cleared (see Optional Feature). Reset asserted mid-count aborts immediately; the first tick after release needs a full presc+1 enabled cycles.
- Prescaler: internal PW-bit pc.
  - When en=1: tick = (pc == presc). On tick pc←0, else pc←pc+1.
  - When en=0: pc holds, no tick.
  - presc=0 gives a tick every enabled cycle.
  - If presc is lowered below the current pc, pc counts up and wraps naturally mod 2^PW before ticking; there is no early tick.
- Priority per cycle: clr > load > tick.
  - clr: count←0, pc←0, tc←0.
  - load: count←load_val (not clamped to modulo), pc←0, tc←0.
  - Both clr and load act regardless of en.
- Tick, up (dir=1):
  - count<modulo: count+1.
  - count≥modulo: wrap→0 (mode_sat=0) or hold count unchanged (mode_sat=1).
- Tick, down (dir=0):
  - count>0: count−1.
  - count==0: wrap→modulo (mode_sat=0) or hold 0 (mode_sat=1).
- Boundary condition: up with count≥modulo, or down with count==0.
- tc: registered 1 for exactly one cycle following each tick taken at the boundary, including saturate holds, so repeated ticks at saturation pulse repeatedly. Otherwise tc=0.
- modulo=0: up ticks always sit at the boundary (count 0→0, tc every tick). Down behaves identically.
- dir, mode_sat and modulo may change any cycle; they are sampled on the tick edge only, with no internal latching.
- Arithmetic is unsigned WIDTH-bit with no carry out. Latency from tick cycle to count/tc update is 1 clk.
- oe is purely combinational from out_en; it is not affected by reset.

Optional Feature:
- Macro: PCNT_CAPTURE_EN.
- Defined: adds ports cap (in 1), cap_val (out WIDTH) and cap_vld (out 1).
  - On a cycle with cap=1: cap_val←count (pre-update value of that cycle), cap_vld←1 for one cycle.
  - cap takes effect regardless of en, clr or load.
  - Reset: cap_val=0, cap_vld=0.
- Undefined: cap, cap_val and cap_vld do not exist; no capture registers are synthesised.

Test Plan:
- WIDTH=8, reset, en=1, dir=1, presc=0, modulo=255, sat=0: count 0,1,…,255,0. tc high exactly one cycle, the cycle count shows 0 after 255.
- presc=3, modulo=5, up: count increments every 4 cycles 0→5→0. tc pulses once per 24 enabled cycles. Dropping en for 7 cycles mid-run delays the sequence by exactly 7 cycles.
- dir=0, sat=1, load_val=3: sequence 3,2,1,0,0,0. tc pulses on each tick taken at 0 (≥2 pulses). Toggling sat=0 then wraps 0→modulo.
- load_val=200 with modulo=10, up, wrap: next tick gives 0 with tc=1. Asserting clr and load in the same cycle gives count=0.
- rstn_n pulsed low asynchronously mid-prescale (pc=2, count=7): count=0, tc=0 immediately. After release, first tick occurs after presc+1 enabled cycles. oe follows out_en through reset.
- PCNT_CAPTURE_EN defined: cap at count=42 while ticking gives cap_val=42 and cap_vld for 1 cycle, while count advances to 43.
